// File: rtl/tcp_tx_datap.sv
// Transmit-side TCP datapath: reads a scheduled flow's state, sizes the next segment against
// unsent data, peer window and MSS, emits a header request, then writes the new sequence back.
module tcp_tx_datap #(
    parameter int FLOWID_W = 8,
    parameter int PTR_W    = 16,
    parameter int MSS      = 1460
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sched_val,
    input  logic [FLOWID_W-1:0] sched_flowid,
    input  logic                sched_rt,
    output logic                sched_rdy,
    output logic                st_rd_val,
    output logic [FLOWID_W-1:0] st_rd_flowid,
    input  logic                st_rd_resp_val,
    input  logic [31:0]         st_our_seq,
    input  logic [31:0]         st_our_una,
    input  logic [31:0]         st_their_ack,
    input  logic [15:0]         st_their_win,
    input  logic [15:0]         st_our_win,
    input  logic [PTR_W:0]      st_tx_tail,
    output logic                hdr_val,
    input  logic                hdr_rdy,
    output logic [FLOWID_W-1:0] hdr_flowid,
    output logic [31:0]         hdr_seq,
    output logic [31:0]         hdr_ack,
    output logic [7:0]          hdr_flags,
    output logic [15:0]         hdr_win,
    output logic [PTR_W:0]      hdr_pay_ptr,
    output logic [PTR_W:0]      hdr_pay_len,
    output logic                st_wr_val,
    output logic [FLOWID_W-1:0] st_wr_flowid,
    output logic [31:0]         st_wr_seq
);

    // state | meaning
    // IDLE  | ready for a scheduler request
    // RD    | state read request pulse
    // WAIT  | waiting for the state read response (captured here)
    // CALC  | size segment from captured state, register header fields
    // EMIT  | header request held until accepted
    // WB    | sequence write-back pulse
    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WAIT, S_CALC, S_EMIT, S_WB
    } state_t;

    localparam logic [7:0] FLAG_ACK = 8'h10;
    localparam logic [7:0] FLAG_PSH = 8'h08;

    state_t                state_q, state_d;
    logic [FLOWID_W-1:0]   flowid_q, flowid_d;
    logic                  rt_q, rt_d;
    logic [31:0]           our_seq_q, our_seq_d;
    logic [31:0]           our_una_q, our_una_d;
    logic [31:0]           their_ack_q, their_ack_d;
    logic [15:0]           their_win_q, their_win_d;
    logic [15:0]           our_win_q, our_win_d;
    logic [PTR_W:0]        tail_q, tail_d;
    logic [31:0]           seg_seq_q, seg_seq_d;
    logic [PTR_W:0]        seg_len_q, seg_len_d;
    logic [7:0]            seg_flags_q, seg_flags_d;
    logic [31:0]           wr_seq_q, wr_seq_d;

    logic [31:0]           start;
    logic [PTR_W:0]        unsent;
    logic [31:0]           unsent32;
    logic [31:0]           inflight;
    logic [31:0]           usable32;
    logic [31:0]           len32;
    logic [31:0]           seg_end;
    logic signed [31:0]    end_ahead;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            flowid_q    <= '0;
            rt_q        <= 1'b0;
            our_seq_q   <= '0;
            our_una_q   <= '0;
            their_ack_q <= '0;
            their_win_q <= '0;
            our_win_q   <= '0;
            tail_q      <= '0;
            seg_seq_q   <= '0;
            seg_len_q   <= '0;
            seg_flags_q <= '0;
            wr_seq_q    <= '0;
        end else begin
            state_q     <= state_d;
            flowid_q    <= flowid_d;
            rt_q        <= rt_d;
            our_seq_q   <= our_seq_d;
            our_una_q   <= our_una_d;
            their_ack_q <= their_ack_d;
            their_win_q <= their_win_d;
            our_win_q   <= our_win_d;
            tail_q      <= tail_d;
            seg_seq_q   <= seg_seq_d;
            seg_len_q   <= seg_len_d;
            seg_flags_q <= seg_flags_d;
            wr_seq_q    <= wr_seq_d;
        end
    end

    // Segment sizing from the captured flow state; all arithmetic wraps naturally.
    always_comb begin
        start     = rt_q ? our_una_q : our_seq_q;
        unsent    = tail_q - start[PTR_W:0];
        unsent32  = 32'(unsent);
        inflight  = start - our_una_q;
        usable32  = (inflight >= {16'd0, their_win_q}) ? 32'd0 : ({16'd0, their_win_q} - inflight);
        len32     = (unsent32 < usable32) ? unsent32 : usable32;
        if (len32 > 32'(MSS)) begin
            len32 = 32'(MSS);
        end
        seg_end   = start + len32;
        // A retransmit only advances our_seq if it reaches past what was already sent.
        end_ahead = $signed(seg_end - our_seq_q);
    end

    always_comb begin
        state_d     = state_q;
        flowid_d    = flowid_q;
        rt_d        = rt_q;
        our_seq_d   = our_seq_q;
        our_una_d   = our_una_q;
        their_ack_d = their_ack_q;
        their_win_d = their_win_q;
        our_win_d   = our_win_q;
        tail_d      = tail_q;
        seg_seq_d   = seg_seq_q;
        seg_len_d   = seg_len_q;
        seg_flags_d = seg_flags_q;
        wr_seq_d    = wr_seq_q;

        case (state_q)
            S_IDLE: begin
                if (sched_val) begin
                    flowid_d = sched_flowid;
                    rt_d     = sched_rt;
                    state_d  = S_RD;
                end
            end
            S_RD: state_d = S_WAIT;
            S_WAIT: begin
                if (st_rd_resp_val) begin
                    our_seq_d   = st_our_seq;
                    our_una_d   = st_our_una;
                    their_ack_d = st_their_ack;
                    their_win_d = st_their_win;
                    our_win_d   = st_our_win;
                    tail_d      = st_tx_tail;
                    state_d     = S_CALC;
                end
            end
            S_CALC: begin
                seg_seq_d   = start;
                seg_len_d   = len32[PTR_W:0];
                seg_flags_d = FLAG_ACK | ((len32 != 32'd0) ? FLAG_PSH : 8'h00);
                if (rt_q && (end_ahead <= 0)) begin
                    wr_seq_d = our_seq_q;
                end else begin
                    wr_seq_d = seg_end;
                end
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (hdr_rdy) begin
                    state_d = S_WB;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign sched_rdy    = (state_q == S_IDLE);
    assign st_rd_val    = (state_q == S_RD);
    assign st_rd_flowid = flowid_q;
    assign hdr_val      = (state_q == S_EMIT);
    assign hdr_flowid   = flowid_q;
    assign hdr_seq      = seg_seq_q;
    assign hdr_ack      = their_ack_q;
    assign hdr_flags    = seg_flags_q;
    assign hdr_win      = our_win_q;
    assign hdr_pay_ptr  = seg_seq_q[PTR_W:0];
    assign hdr_pay_len  = seg_len_q;
    assign st_wr_val    = (state_q == S_WB);
    assign st_wr_flowid = flowid_q;
    assign st_wr_seq    = wr_seq_q;

endmodule

// File: tb/tb_tcp_tx_datap.sv
// Directed bench for tcp_tx_datap: table of flow-state vectors with hand-computed segments,
// plus stall, stray-response and mid-segment reset sequences.
module tb_tcp_tx_datap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sched_val = 1'b0;
    logic [7:0]  sched_flowid = '0;
    logic        sched_rt = 1'b0;
    logic        sched_rdy;
    logic        st_rd_val;
    logic [7:0]  st_rd_flowid;
    logic        st_rd_resp_val = 1'b0;
    logic [31:0] st_our_seq = '0;
    logic [31:0] st_our_una = '0;
    logic [31:0] st_their_ack = '0;
    logic [15:0] st_their_win = '0;
    logic [15:0] st_our_win = '0;
    logic [16:0] st_tx_tail = '0;
    logic        hdr_val;
    logic        hdr_rdy = 1'b0;
    logic [7:0]  hdr_flowid;
    logic [31:0] hdr_seq;
    logic [31:0] hdr_ack;
    logic [7:0]  hdr_flags;
    logic [15:0] hdr_win;
    logic [16:0] hdr_pay_ptr;
    logic [16:0] hdr_pay_len;
    logic        st_wr_val;
    logic [7:0]  st_wr_flowid;
    logic [31:0] st_wr_seq;

    tcp_tx_datap #(.FLOWID_W(8), .PTR_W(16), .MSS(1460)) dut (
        .clk(clk), .rst_n(rst_n),
        .sched_val(sched_val), .sched_flowid(sched_flowid), .sched_rt(sched_rt), .sched_rdy(sched_rdy),
        .st_rd_val(st_rd_val), .st_rd_flowid(st_rd_flowid), .st_rd_resp_val(st_rd_resp_val),
        .st_our_seq(st_our_seq), .st_our_una(st_our_una), .st_their_ack(st_their_ack),
        .st_their_win(st_their_win), .st_our_win(st_our_win), .st_tx_tail(st_tx_tail),
        .hdr_val(hdr_val), .hdr_rdy(hdr_rdy), .hdr_flowid(hdr_flowid), .hdr_seq(hdr_seq),
        .hdr_ack(hdr_ack), .hdr_flags(hdr_flags), .hdr_win(hdr_win), .hdr_pay_ptr(hdr_pay_ptr),
        .hdr_pay_len(hdr_pay_len), .st_wr_val(st_wr_val), .st_wr_flowid(st_wr_flowid),
        .st_wr_seq(st_wr_seq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        rt;
        logic [31:0] seq;
        logic [31:0] una;
        logic [15:0] twin;
        logic [16:0] tail;
        int          lat;
        int          stall;
        logic [31:0] e_seq;
        logic [16:0] e_len;
        logic [7:0]  e_flags;
        logic [31:0] e_wr;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_garbage();
        st_our_seq   = 32'hDEAD_BEEF;
        st_our_una   = 32'h1234_5678;
        st_their_ack = 32'hBAD0_BAD0;
        st_their_win = 16'h0003;
        st_our_win   = 16'hEEEE;
        st_tx_tail   = 17'h1_5555;
    endtask

    // Request, answer the state read after lat cycles, and wait for hdr_val.
    task automatic start_to_emit(input vec_t v, input logic [7:0] fid,
                                 input logic [31:0] ack, input logic [15:0] owin);
        int n;
        int t0;
        @(negedge clk);
        chk("sched_rdy_idle", 32'(sched_rdy), 32'd1);
        sched_val = 1'b1; sched_flowid = fid; sched_rt = v.rt;
        t0 = cyc;
        @(negedge clk);
        sched_val = 1'b0; sched_flowid = 8'hFF; sched_rt = ~v.rt;
        n = 0;
        while (!st_rd_val && n < 10) begin @(negedge clk); n++; end
        chk("st_rd_val", 32'(st_rd_val), 32'd1);
        chk("st_rd_flowid", 32'(st_rd_flowid), 32'(fid));
        repeat (v.lat) @(negedge clk);
        st_rd_resp_val = 1'b1;
        st_our_seq = v.seq; st_our_una = v.una; st_their_ack = ack;
        st_their_win = v.twin; st_our_win = owin; st_tx_tail = v.tail;
        @(negedge clk);
        st_rd_resp_val = 1'b0;
        drive_garbage();
        n = 0;
        while (!hdr_val && n < 20) begin @(negedge clk); n++; end
        chk("hdr_val", 32'(hdr_val), 32'd1);
        if (v.lat == 1) chk("latency", 32'(cyc - t0), 32'd4);
    endtask

    task automatic chk_hdr(input vec_t v, input logic [7:0] fid,
                           input logic [31:0] ack, input logic [15:0] owin);
        chk("hdr_flowid", 32'(hdr_flowid), 32'(fid));
        chk("hdr_seq", hdr_seq, v.e_seq);
        chk("hdr_ack", hdr_ack, ack);
        chk("hdr_win", 32'(hdr_win), 32'(owin));
        chk("hdr_flags", 32'(hdr_flags), 32'(v.e_flags));
        chk("hdr_pay_len", 32'(hdr_pay_len), 32'(v.e_len));
        chk("hdr_pay_ptr", 32'(hdr_pay_ptr), 32'(v.e_seq[16:0]));
    endtask

    task automatic run_vec(input vec_t v, input logic [7:0] fid);
        logic [31:0] ack;
        logic [15:0] owin;
        ack  = {fid, 24'h00_AC01} ^ v.seq;
        owin = {fid, 8'h5A};
        start_to_emit(v, fid, ack, owin);
        chk_hdr(v, fid, ack, owin);
        chk("sched_rdy_busy", 32'(sched_rdy), 32'd0);
        repeat (v.stall) @(negedge clk);
        if (v.stall > 0) begin
            chk("hdr_val_stalled", 32'(hdr_val), 32'd1);
            chk_hdr(v, fid, ack, owin);
        end
        hdr_rdy = 1'b1;
        @(negedge clk);
        hdr_rdy = 1'b0;
        chk("st_wr_val", 32'(st_wr_val), 32'd1);
        chk("st_wr_seq", st_wr_seq, v.e_wr);
        chk("st_wr_flowid", 32'(st_wr_flowid), 32'(fid));
        chk("hdr_val_after", 32'(hdr_val), 32'd0);
        @(negedge clk);
        chk("st_wr_val_pulse", 32'(st_wr_val), 32'd0);
        chk("sched_rdy_back", 32'(sched_rdy), 32'd1);
    endtask

    initial begin
        int wr_seen;
        logic [31:0] ack_r;
        //                rt  seq           una           twin      tail       lat st  e_seq         e_len     flags  e_wr
        vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0000_0100, 16'd1000, 17'h001C8, 1, 0, 32'h0000_0100, 17'd200,  8'h18, 32'h0000_01C8};
        vecs[1]  = '{1'b0, 32'h0000_2000, 32'h0000_2000, 16'hFFFF, 17'h03388, 2, 3, 32'h0000_2000, 17'd1460, 8'h18, 32'h0000_25B4};
        vecs[2]  = '{1'b0, 32'h0000_0400, 32'h0000_0100, 16'h0200, 17'h00800, 1, 0, 32'h0000_0400, 17'd0,    8'h10, 32'h0000_0400};
        vecs[3]  = '{1'b0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 16'd1000, 17'h00010, 3, 1, 32'hFFFF_FFF0, 17'd32,   8'h18, 32'h0000_0010};
        vecs[4]  = '{1'b1, 32'h0000_0300, 32'h0000_0100, 16'h1000, 17'h00300, 1, 2, 32'h0000_0100, 17'h200,  8'h18, 32'h0000_0300};
        vecs[5]  = '{1'b1, 32'h0000_0180, 32'h0000_0100, 16'h1000, 17'h00400, 4, 0, 32'h0000_0100, 17'h300,  8'h18, 32'h0000_0400};
        vecs[6]  = '{1'b0, 32'h0000_0200, 32'h0000_0100, 16'h0100, 17'h01000, 1, 0, 32'h0000_0200, 17'd0,    8'h10, 32'h0000_0200};
        vecs[7]  = '{1'b0, 32'h0000_0200, 32'h0000_0100, 16'h0140, 17'h01000, 2, 0, 32'h0000_0200, 17'h40,   8'h18, 32'h0000_0240};
        vecs[8]  = '{1'b0, 32'h0000_0500, 32'h0000_0500, 16'h1000, 17'h00500, 1, 0, 32'h0000_0500, 17'd0,    8'h10, 32'h0000_0500};
        vecs[9]  = '{1'b1, 32'h0000_1800, 32'h0000_1000, 16'h0100, 17'h01800, 1, 0, 32'h0000_1000, 17'h100,  8'h18, 32'h0000_1800};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 16'hFFFF, 17'h005B5, 2, 0, 32'h0000_0000, 17'd1460, 8'h18, 32'h0000_05B4};

        drive_garbage();
        #12;
        chk("rst_sched_rdy", 32'(sched_rdy), 32'd1);
        chk("rst_st_rd_val", 32'(st_rd_val), 32'd0);
        chk("rst_hdr_val", 32'(hdr_val), 32'd0);
        chk("rst_st_wr_val", 32'(st_wr_val), 32'd0);
        chk("rst_hdr_seq", hdr_seq, 32'd0);
        chk("rst_st_wr_seq", st_wr_seq, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // A response while idle must not start or disturb anything.
        @(negedge clk);
        st_rd_resp_val = 1'b1;
        @(negedge clk);
        st_rd_resp_val = 1'b0;
        chk("stray_resp_idle", 32'(sched_rdy), 32'd1);
        chk("stray_resp_no_rd", 32'(st_rd_val), 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], 8'(i + 8'h30));
        end

        // Stall in EMIT for 10 cycles with a stray response, then reset mid-segment.
        ack_r = {8'h77, 24'h00_AC01} ^ vecs[0].seq;
        start_to_emit(vecs[0], 8'h77, ack_r, 16'h775A);
        wr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            st_rd_resp_val = (i == 4);
            @(negedge clk);
            if (st_wr_val) wr_seen++;
            chk("stall_hdr_val", 32'(hdr_val), 32'd1);
            chk("stall_hdr_seq", hdr_seq, vecs[0].e_seq);
            chk("stall_hdr_len", 32'(hdr_pay_len), 32'(vecs[0].e_len));
            chk("stall_hdr_ack", hdr_ack, ack_r);
        end
        st_rd_resp_val = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hdr_val", 32'(hdr_val), 32'd0);
        chk("mid_rst_sched_rdy", 32'(sched_rdy), 32'd1);
        chk("mid_rst_hdr_seq", hdr_seq, 32'd0);
        chk("mid_rst_hdr_len", 32'(hdr_pay_len), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (st_wr_val) wr_seen++;
            if (i == 2) rst_n = 1'b1;
        end
        chk("mid_rst_no_wb", 32'(wr_seen), 32'd0);
        chk("post_rst_idle", 32'(sched_rdy), 32'd1);

        run_vec(vecs[1], 8'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
